mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//  Single-port 16-location memory that serves the memory verification env's driver interface.
//  Accepts read/write requests over a valid/ready handshake.
//  Returns read data over a registered, back-pressurable response channel.
//  Writes commit on acceptance and produce no response.
//  Optionally flags reads of never-written locations.
// PARAMETERS
//  DEPTH       16  number of memory locations (= size_of_memory_location)
//  ADDR_W      4   address width, must equal $clog2(DEPTH)
//  DATA_W      32  data width of each location
// PORTS
//  clk        in   1       clock, all logic on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       block can accept the request this cycle
//  req_we     in   1       1 = write, 0 = read
//  req_addr   in   ADDR_W  target location
//  req_wdata  in   DATA_W  write data (ignored for reads)
//  rsp_valid  out  1       read response present
//  rsp_ready  in   1       consumer accepts the response
//  rsp_rdata  out  DATA_W  read data
//  rsp_err    out  1       read hit a never-written location (MEM_RD_ERR_EN only)
//  wr_count   out  8       accepted writes, saturating at 8'hFF
//  rd_count   out  8       accepted reads, saturating at 8'hFF
// BEHAVIOUR
//  - Reset (async assert, sync release)
//    - All memory locations = 0.
//    - rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_count=0, rd_count=0, FSM=IDLE.
//    - req_ready=1 after reset releases.
//  - Acceptance: a request is accepted on a cycle with req_valid & req_ready.
//  - req_ready = ~rsp_valid | rsp_ready (combinational). The response slot is one deep.
//  - Write accept: mem[req_addr] <= req_wdata at that edge. No response. wr_count++.
//  - Read accept:
//    - rsp_rdata <= mem[req_addr] and rsp_valid <= 1 at that edge, so latency is 1 cycle. rd_count++.
//    - A read accepted the cycle after a write to the same address returns the new data.
//  - FSM:
//    - IDLE: read accept -> RSP. Write accept stays IDLE.
//    - RSP (rsp_valid=1):
//      - rsp_ready=1 with a new read accept -> stay RSP, response data updated.
//      - rsp_ready=1 with a write or no accept -> IDLE, rsp_valid=0.
//      - rsp_ready=0 -> hold; rsp_rdata and rsp_err stable, req_ready=0.
//  - Writes are stalled while a response is pending and not consumed, so request order is preserved.
//  - rsp_rdata holds its last value when rsp_valid=0.
//  - Counters saturate at 8'hFF and never wrap.
//  - Address range: req_addr >= DEPTH is only possible if DEPTH < 2**ADDR_W.
//    - Write: dropped, but still counted.
//    - Read: returns 0, with rsp_err=1 when MEM_RD_ERR_EN.
//  - Reset mid-response: the pending response is discarded and rsp_valid goes 0 immediately.
// CONFIGURATION
//  - MEM_RD_ERR_EN defined:
//    - A DEPTH-bit written map is kept, reset to 0, with bit set on each write accept.
//    - rsp_err <= ~written[req_addr] on read accept.
//  - MEM_RD_ERR_EN undefined: no written map; rsp_err is tied to 0.
// TESTING
//  1. Reset, then write addr 3 = 32'hDEAD_BEEF, then read addr 3 -> rsp_valid 1 cycle later, rsp_rdata=32'hDEAD_BEEF, wr_count=1, rd_count=1.
//  2. Read addr 5 with rsp_ready=0 for 4 cycles -> req_ready=0 and rsp_rdata stable for all 4 cycles; a held write to addr 5 is not committed until rsp_ready=1.
//  3. Back-to-back reads 0..15 with rsp_ready=1 after writing mem[i]=i -> 16 consecutive responses, data 0..15, no bubbles.
//  4. Write addr 7 = 1 and read addr 7 on the next cycle -> rsp_rdata=1. Also cover the read-after-write of the same address with no idle cycle between them.
//  5. MEM_RD_ERR_EN: read addr 9 after reset -> rsp_err=1, rsp_rdata=0. Write addr 9, then read it again -> rsp_err=0. Without the macro, rsp_err=0 always.
//  6. 300 writes -> wr_count=8'hFF. Assert rst_n with a response pending -> rsp_valid=0 at once, then reading any address returns 0.

Source files
------------

// File: rtl/mem_responder.sv
// mem_responder: single-port DEPTH x DATA_W memory behind a valid/ready request port.
// Latency: writes commit at the accept edge; read data is registered one cycle after accept.
// Backpressure: one-deep response slot; req_ready drops while a response waits on rsp_ready.
// Optional feature macro: MEM_RD_ERR_EN (flags reads of never-written locations on rsp_err).
module mem_responder #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [7:0]        wr_count,
  output logic [7:0]        rd_count
);

  typedef enum logic {IDLE, RSP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [7:0]        wr_count_q, wr_count_d;
  logic [7:0]        rd_count_q, rd_count_d;

  logic              acc, wr_acc, rd_acc, addr_ok;
  logic [31:0]       addr_ext;
  logic [DATA_W-1:0] rd_word;

  // The slot frees up in the same cycle it is being consumed, so back-to-back reads run bubble-free.
  assign rsp_valid = (state_q == RSP);
  assign req_ready = ~rsp_valid | rsp_ready;
  assign acc       = req_valid & req_ready;
  assign wr_acc    = acc & req_we;
  assign rd_acc    = acc & ~req_we;

  // Out-of-range addresses only exist when DEPTH is not a power of two.
  assign addr_ext  = {{(32-ADDR_W){1'b0}}, req_addr};
  assign addr_ok   = (addr_ext < 32'(DEPTH));
  assign rd_word   = addr_ok ? mem_q[req_addr] : '0;

  assign rsp_rdata = rsp_rdata_q;
  assign wr_count  = wr_count_q;
  assign rd_count  = rd_count_q;

  // Next-state for the response slot FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (rd_acc) state_d = RSP;
      RSP:  if (rsp_ready) state_d = rd_acc ? RSP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory write, response data capture and saturating counters.
  always_comb begin
    mem_d       = mem_q;
    rsp_rdata_d = rsp_rdata_q;
    wr_count_d  = wr_count_q;
    rd_count_d  = rd_count_q;
    if (wr_acc) begin
      if (addr_ok) mem_d[req_addr] = req_wdata;
      if (wr_count_q != 8'hFF) wr_count_d = wr_count_q + 8'd1;
    end
    if (rd_acc) begin
      rsp_rdata_d = rd_word;
      if (rd_count_q != 8'hFF) rd_count_d = rd_count_q + 8'd1;
    end
  end

  // State, memory and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_rdata_q <= '0;
      wr_count_q  <= '0;
      rd_count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rsp_rdata_q <= rsp_rdata_d;
      wr_count_q  <= wr_count_d;
      rd_count_q  <= rd_count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

`ifdef MEM_RD_ERR_EN
  logic [DEPTH-1:0] written_q, written_d;
  logic             rsp_err_q, rsp_err_d;

  // Track written locations; a read of an unwritten or out-of-range location reports an error.
  always_comb begin
    written_d = written_q;
    rsp_err_d = rsp_err_q;
    if (wr_acc && addr_ok) written_d[req_addr] = 1'b1;
    if (rd_acc) rsp_err_d = addr_ok ? ~written_q[req_addr] : 1'b1;
  end

  // Written map and error flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      written_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      written_q <= written_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed testbench for mem_responder: hand-computed expectations, one checking task.
// Inputs are driven 1 ns after the rising edge; outputs are checked before the next edge.
// Build with +define+MEM_RD_ERR_EN to exercise the error flag expectations.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we, rsp_ready;
  logic [3:0]  req_addr;
  logic [31:0] req_wdata;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  wr_count, rd_count;

  int n_cmp = 0;
  int n_err = 0;

  logic err_exp;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(16), .ADDR_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .wr_count(wr_count), .rd_count(rd_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [3:0] a, input logic [31:0] d);
    req_valid = v;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  initial begin
`ifdef MEM_RD_ERR_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    tick();
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    check_eq("rst_wr_count",  {24'd0, wr_count}, 32'd0);
    check_eq("rst_rd_count",  {24'd0, rd_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // 1: write then read addr 3
    drive(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF);
    tick();
    check_eq("t1_no_wr_rsp", {31'd0, rsp_valid}, 32'd0);
    drive(1'b1, 1'b0, 4'd3, 32'd0);
    tick();
    check_eq("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("t1_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check_eq("t1_wr_count", {24'd0, wr_count}, 32'd1);
    check_eq("t1_rd_count", {24'd0, rd_count}, 32'd1);
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    tick();
    check_eq("t1_idle_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("t1_rdata_hold", rsp_rdata, 32'hDEAD_BEEF);

    // 2: read addr 5 under backpressure, held write not committed early
    drive(1'b1, 1'b1, 4'd5, 32'h0000_0055);
    tick();
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 4'd5, 32'd0);
    tick();
    drive(1'b1, 1'b1, 4'd5, 32'h0000_00AA);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("t2_req_ready_%0d", i), {31'd0, req_ready}, 32'd0);
      check_eq($sformatf("t2_rsp_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
      check_eq($sformatf("t2_rdata_%0d", i), rsp_rdata, 32'h0000_0055);
      tick();
    end
    check_eq("t2_wr_held", {24'd0, wr_count}, 32'd2);
    check_eq("t2_rd_count", {24'd0, rd_count}, 32'd2);
    rsp_ready = 1'b1;
    #1;
    check_eq("t2_req_ready_rel", {31'd0, req_ready}, 32'd1);
    tick();
    check_eq("t2_wr_commit", {24'd0, wr_count}, 32'd3);
    check_eq("t2_after_wr_valid", {31'd0, rsp_valid}, 32'd0);
    drive(1'b1, 1'b0, 4'd5, 32'd0);
    tick();
    check_eq("t2_new_data", rsp_rdata, 32'h0000_00AA);

    // 3: fill mem[i]=i, then 16 back-to-back reads
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, 4'(i), 32'(i));
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 4'(i), 32'd0);
      tick();
      check_eq($sformatf("t3_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
      check_eq($sformatf("t3_rdata_%0d", i), rsp_rdata, 32'(i));
    end
    check_eq("t3_wr_count", {24'd0, wr_count}, 32'd19);
    check_eq("t3_rd_count", {24'd0, rd_count}, 32'd19);

    // 4: read-after-write of addr 7 with no gap
    drive(1'b1, 1'b1, 4'd7, 32'd1);
    tick();
    drive(1'b1, 1'b0, 4'd7, 32'd0);
    tick();
    check_eq("t4_raw_valid", {31'd0, rsp_valid}, 32'd1);
    check_eq("t4_raw_rdata", rsp_rdata, 32'd1);
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    tick();

    // 6: counter saturation (20 writes so far)
    for (int i = 0; i < 235; i++) begin
      drive(1'b1, 1'b1, 4'(i), 32'h1000 + 32'(i));
      tick();
    end
    check_eq("t6_wr_255", {24'd0, wr_count}, 32'hFF);
    for (int i = 0; i < 45; i++) begin
      drive(1'b1, 1'b1, 4'(i), 32'h2000 + 32'(i));
      tick();
    end
    check_eq("t6_wr_sat", {24'd0, wr_count}, 32'hFF);
    check_eq("t6_rd_count", {24'd0, rd_count}, 32'd20);

    // 6: reset with a pending response
    rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 4'd2, 32'd0);
    tick();
    check_eq("t6_pending", {31'd0, rsp_valid}, 32'd1);
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("t6_rst_wr", {24'd0, wr_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick();
    drive(1'b1, 1'b0, 4'd4, 32'd0);
    tick();
    check_eq("t6_rd_zero", rsp_rdata, 32'd0);
    check_eq("t6_rd_count_rst", {24'd0, rd_count}, 32'd1);

    // 5: error flag on never-written location
    drive(1'b1, 1'b0, 4'd9, 32'd0);
    tick();
    check_eq("t5_rdata_unwr", rsp_rdata, 32'd0);
    check_eq("t5_err_unwr", {31'd0, rsp_err}, {31'd0, err_exp});
    drive(1'b1, 1'b1, 4'd9, 32'h0000_0099);
    tick();
    drive(1'b1, 1'b0, 4'd9, 32'd0);
    tick();
    check_eq("t5_rdata_wr", rsp_rdata, 32'h0000_0099);
    check_eq("t5_err_wr", {31'd0, rsp_err}, 32'd0);
    drive(1'b0, 1'b0, 4'd0, 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
